vga_frame_scanner: RTL and testbench

Display-side scan engine that consumes the RGB565 framebuffer filled by the SD-card storage path and drives a 640×480@60 Hz VGA monitor from the 25 MHz pixel clock. It generates standard VGA timing and issues framebuffer read addresses with 2× pixel/line doubling of a 320×240 image. It aligns sync and blanking with the synchronous-RAM read latency and outputs RGB444. The image to show is latched once per frame, so switching images never tears mid-frame.

---
 rtl/vga_frame_scanner_if.sv | 11 +
 rtl/vga_frame_scanner.sv | 123 ++++++++++++
 tb/tb_vga_frame_scanner.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_scanner_if.sv
// Framebuffer read port between the VGA scan engine (master) and its RAM (slave).
interface vga_frame_scanner_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [15:0]       rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_frame_scanner.sv
// VGA scan engine: standard timing, 2x-doubled framebuffer reads, sync/blank
// aligned to the RAM read latency, RGB565 -> RGB444 output, per-frame image latch.
module vga_frame_scanner #(
  parameter int FRAME_PIX = 76800,
  parameter int ADDR_W    = 18,
  parameter int RAM_LAT   = 1,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                clk_25MHz,
  input  logic                rst_n,
  input  logic [1:0]          image_select,
  input  logic                display_en,
  vga_frame_scanner_if.master fb,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_de,
  output logic [11:0]         vga_rgb,
  output logic                frame_start
);
  localparam int PIPE = 2 + RAM_LAT;

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] H_SS    = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SS    = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_VIS + V_FP + V_SYNC);

  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(H_VIS / 2);
  localparam logic [ADDR_W-1:0] FRAME_PIX_C = ADDR_W'(FRAME_PIX);

  logic [9:0]        h_cnt_q, h_cnt_d;
  logic [9:0]        v_cnt_q, v_cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] base;
  logic              rd_en_q;
  logic              frame_start_q, frame_start_d;
  logic [PIPE-1:0]   de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [11:0]       rgb_q, rgb_d;
  logic              h_last, v_last, active, hs_now, vs_now;
  logic              unused_rd_bits;

  assign unused_rd_bits = ^{fb.rd_data[11], fb.rd_data[6:5], fb.rd_data[0]};

  always_comb begin
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    active = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs_now = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    vs_now = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));

    h_cnt_d    = h_last ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    if (h_last) begin
      v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      // Each stored row is shown on two lines, so step after the odd one.
      if (v_last) begin
        row_base_d = '0;
      end else if (v_cnt_q[0] && (v_cnt_q < V_VIS_C)) begin
        row_base_d = row_base_q + ROW_STRIDE;
      end
    end

    frame_start_d = h_last && v_last;
    sel_d         = frame_start_d ? image_select : sel_q;

    base      = ADDR_W'(sel_q) * FRAME_PIX_C;
    rd_addr_d = active ? (base + row_base_q + ADDR_W'(h_cnt_q[9:1])) : rd_addr_q;

    // de_pipe_q[PIPE-2] is the active flag of the pixel whose data is on rd_data now.
    rgb_d = (de_pipe_q[PIPE-2] && display_en)
          ? {fb.rd_data[15:12], fb.rd_data[10:7], fb.rd_data[4:1]}
          : 12'h000;
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sel_q         <= '0;
      row_base_q    <= '0;
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sel_q         <= sel_d;
      row_base_q    <= row_base_d;
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= active;
      frame_start_q <= frame_start_d;
      de_pipe_q     <= {de_pipe_q[PIPE-2:0], active};
      hs_pipe_q     <= {hs_pipe_q[PIPE-2:0], hs_now};
      vs_pipe_q     <= {vs_pipe_q[PIPE-2:0], vs_now};
      rgb_q         <= rgb_d;
    end
  end

  assign fb.rd_addr   = rd_addr_q;
  assign fb.rd_en     = rd_en_q;
  assign vga_hsync    = hs_pipe_q[PIPE-1];
  assign vga_vsync    = vs_pipe_q[PIPE-1];
  assign vga_de       = de_pipe_q[PIPE-1];
  assign vga_rgb      = rgb_q;
  assign frame_start  = frame_start_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a full-size instance plus two reduced-geometry
// instances (RAM_LAT 1 and 3) checked every cycle against a cycle-index model.
module tb_vga_frame_scanner;
  localparam int NI = 3;
  localparam int HVIS_P [NI] = '{640, 40, 40};
  localparam int HFP_P  [NI] = '{16, 4, 4};
  localparam int HSY_P  [NI] = '{96, 8, 8};
  localparam int HBP_P  [NI] = '{48, 8, 8};
  localparam int VVIS_P [NI] = '{480, 30, 30};
  localparam int VFP_P  [NI] = '{10, 2, 2};
  localparam int VSY_P  [NI] = '{2, 2, 2};
  localparam int VBP_P  [NI] = '{33, 4, 4};
  localparam int FPIX_P [NI] = '{76800, 300, 400};
  localparam int AW_P   [NI] = '{18, 18, 10};
  localparam int LAT_P  [NI] = '{1, 1, 3};

  logic          clk;
  logic          rst_n;
  logic [1:0]    image_select;
  logic          display_en;
  logic [NI-1:0] hs, vs, de, fs;
  logic [11:0]   rgb [NI];
  logic [17:0]   obs_addr [NI];
  logic [NI-1:0] obs_en;
  logic [15:0]   rp [NI][3];

  int compared;
  int mismatched;

  int          n_edge    [NI];
  int          sel_frame [NI][32];
  logic [17:0] last_addr [NI];
  logic        den_edge;
  int          hs_low [NI];
  int          vs_low [NI];
  int          de_hi  [NI];
  int          fs_cnt [NI];

  initial clk = 1'b0;
  always #20 clk = ~clk;

  vga_frame_scanner_if #(.ADDR_W(18)) fb0 ();
  vga_frame_scanner_if #(.ADDR_W(18)) fb1 ();
  vga_frame_scanner_if #(.ADDR_W(10)) fb2 ();

  vga_frame_scanner #(
    .FRAME_PIX(FPIX_P[0]), .ADDR_W(AW_P[0]), .RAM_LAT(LAT_P[0]),
    .H_VIS(HVIS_P[0]), .H_FP(HFP_P[0]), .H_SYNC(HSY_P[0]), .H_BP(HBP_P[0]),
    .V_VIS(VVIS_P[0]), .V_FP(VFP_P[0]), .V_SYNC(VSY_P[0]), .V_BP(VBP_P[0])
  ) u_full (
    .clk_25MHz(clk), .rst_n(rst_n), .image_select(image_select), .display_en(display_en),
    .fb(fb0), .vga_hsync(hs[0]), .vga_vsync(vs[0]), .vga_de(de[0]), .vga_rgb(rgb[0]),
    .frame_start(fs[0])
  );

  vga_frame_scanner #(
    .FRAME_PIX(FPIX_P[1]), .ADDR_W(AW_P[1]), .RAM_LAT(LAT_P[1]),
    .H_VIS(HVIS_P[1]), .H_FP(HFP_P[1]), .H_SYNC(HSY_P[1]), .H_BP(HBP_P[1]),
    .V_VIS(VVIS_P[1]), .V_FP(VFP_P[1]), .V_SYNC(VSY_P[1]), .V_BP(VBP_P[1])
  ) u_small1 (
    .clk_25MHz(clk), .rst_n(rst_n), .image_select(image_select), .display_en(display_en),
    .fb(fb1), .vga_hsync(hs[1]), .vga_vsync(vs[1]), .vga_de(de[1]), .vga_rgb(rgb[1]),
    .frame_start(fs[1])
  );

  vga_frame_scanner #(
    .FRAME_PIX(FPIX_P[2]), .ADDR_W(AW_P[2]), .RAM_LAT(LAT_P[2]),
    .H_VIS(HVIS_P[2]), .H_FP(HFP_P[2]), .H_SYNC(HSY_P[2]), .H_BP(HBP_P[2]),
    .V_VIS(VVIS_P[2]), .V_FP(VFP_P[2]), .V_SYNC(VSY_P[2]), .V_BP(VBP_P[2])
  ) u_small3 (
    .clk_25MHz(clk), .rst_n(rst_n), .image_select(image_select), .display_en(display_en),
    .fb(fb2), .vga_hsync(hs[2]), .vga_vsync(vs[2]), .vga_de(de[2]), .vga_rgb(rgb[2]),
    .frame_start(fs[2])
  );

  // RAM contents: a hash of the address, with address 0 holding magenta.
  function automatic logic [15:0] ram_fn(input logic [17:0] a);
    logic [31:0] x;
    if (a == 18'd0) return 16'hF81F;
    x = {14'd0, a} * 32'h9E37_79B1;
    return x[31:16] ^ x[15:0];
  endfunction

  always_comb begin
    obs_addr[0] = fb0.rd_addr;
    obs_addr[1] = fb1.rd_addr;
    obs_addr[2] = {8'd0, fb2.rd_addr};
    obs_en      = {fb2.rd_en, fb1.rd_en, fb0.rd_en};
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      rp[k][0] <= ram_fn(obs_addr[k]);
      rp[k][1] <= rp[k][0];
      rp[k][2] <= rp[k][1];
    end
  end

  assign fb0.rd_data = rp[0][LAT_P[0]-1];
  assign fb1.rd_data = rp[1][LAT_P[1]-1];
  assign fb2.rd_data = rp[2][LAT_P[2]-1];

  // ---------------- reference model (pure arithmetic on the edge count) ----
  function automatic int htot(input int k);
    return HVIS_P[k] + HFP_P[k] + HSY_P[k] + HBP_P[k];
  endfunction

  function automatic int fcyc(input int k);
    return htot(k) * (VVIS_P[k] + VFP_P[k] + VSY_P[k] + VBP_P[k]);
  endfunction

  function automatic bit is_active(input int k, input int m);
    int pos;
    pos = m % fcyc(k);
    return ((pos % htot(k)) < HVIS_P[k]) && ((pos / htot(k)) < VVIS_P[k]);
  endfunction

  function automatic logic [17:0] addr_of(input int k, input int m);
    int     pos, h, v;
    longint a;
    pos = m % fcyc(k);
    h   = pos % htot(k);
    v   = pos / htot(k);
    a   = longint'(sel_frame[k][(m / fcyc(k)) % 32]) * longint'(FPIX_P[k])
        + longint'((v / 2) * (HVIS_P[k] / 2) + h / 2);
    a   = a & ((longint'(1) << AW_P[k]) - 1);
    return 18'(a);
  endfunction

  function automatic logic [11:0] to444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NI; k++) begin
      n_edge[k]    = 0;
      last_addr[k] = '0;
      for (int f = 0; f < 32; f++) sel_frame[k][f] = 0;
    end
  endtask

  task automatic advance_model();
    for (int k = 0; k < NI; k++) begin
      if (n_edge[k] % fcyc(k) == fcyc(k) - 1)
        sel_frame[k][((n_edge[k] + 1) / fcyc(k)) % 32] = int'(image_select);
      n_edge[k]++;
      if (is_active(k, n_edge[k] - 1)) last_addr[k] = addr_of(k, n_edge[k] - 1);
    end
    den_edge = display_en;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < NI; k++) begin
      chk("rst_rd_addr", k, 32'(obs_addr[k]), 32'd0);
      chk("rst_rd_en",   k, 32'(obs_en[k]),   32'd0);
      chk("rst_hsync",   k, 32'(hs[k]),       32'd1);
      chk("rst_vsync",   k, 32'(vs[k]),       32'd1);
      chk("rst_de",      k, 32'(de[k]),       32'd0);
      chk("rst_rgb",     k, 32'(rgb[k]),      32'd0);
      chk("rst_fs",      k, 32'(fs[k]),       32'd0);
    end
  endtask

  task automatic check_model();
    int n, pipe, m, pos, h, v;
    logic e_hs, e_vs, e_de;
    logic [11:0] e_rgb;
    for (int k = 0; k < NI; k++) begin
      n    = n_edge[k];
      pipe = 2 + LAT_P[k];
      chk("frame_start", k, 32'(fs[k]), 32'((n > 0) && (n % fcyc(k) == 0)));
      chk("rd_en",       k, 32'(obs_en[k]), 32'((n >= 1) && is_active(k, n - 1)));
      chk("rd_addr",     k, 32'(obs_addr[k]), 32'(last_addr[k]));
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 12'h000;
      if (n >= pipe) begin
        m    = n - pipe;
        pos  = m % fcyc(k);
        h    = pos % htot(k);
        v    = pos / htot(k);
        e_hs = !((h >= HVIS_P[k] + HFP_P[k]) && (h < HVIS_P[k] + HFP_P[k] + HSY_P[k]));
        e_vs = !((v >= VVIS_P[k] + VFP_P[k]) && (v < VVIS_P[k] + VFP_P[k] + VSY_P[k]));
        e_de = is_active(k, m);
        if (e_de && den_edge) e_rgb = to444(ram_fn(addr_of(k, m)));
      end
      chk("vga_hsync", k, 32'(hs[k]), 32'(e_hs));
      chk("vga_vsync", k, 32'(vs[k]), 32'(e_vs));
      chk("vga_de",    k, 32'(de[k]), 32'(e_de));
      chk("vga_rgb",   k, 32'(rgb[k]), 32'(e_rgb));
      if (n == pipe && den_edge) begin
        chk("first_pixel_rgb", k, 32'(rgb[k]), 32'h0F0F);
        chk("first_pixel_de",  k, 32'(de[k]),  32'd1);
      end
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NI; k++) begin
      hs_low[k] = 0; vs_low[k] = 0; de_hi[k] = 0; fs_cnt[k] = 0;
    end
  endtask

  task automatic cycle(input bit rnd);
    @(negedge clk);
    advance_model();
    check_model();
    for (int k = 0; k < NI; k++) begin
      if (!hs[k]) hs_low[k]++;
      if (!vs[k]) vs_low[k]++;
      if (de[k])  de_hi[k]++;
      if (fs[k])  fs_cnt[k]++;
    end
    if (rnd) begin
      if ($urandom_range(0, 399) == 0) image_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) display_en = ~display_en;
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    image_select = 2'($urandom_range(0, 3));
    display_en   = 1'b1;
    den_edge     = 1'b1;
    reset_model();
    clear_counts();

    repeat (3) @(negedge clk);
    check_reset_vals();
    $display("step: reset held, image_select=%0d", image_select);

    rst_n = 1'b1;
    reset_model();
    repeat (200) cycle(1'b0);
    image_select = 2'($urandom_range(1, 3));
    $display("step: mid-frame image_select -> %0d", image_select);

    clear_counts();
    repeat (fcyc(1)) cycle(1'b0);
    for (int k = 1; k < NI; k++) begin
      chk("frame_hs_low", k, 32'(hs_low[k]), 32'(HSY_P[k] * fcyc(k) / htot(k)));
      chk("frame_vs_low", k, 32'(vs_low[k]), 32'(VSY_P[k] * htot(k)));
      chk("frame_de_hi",  k, 32'(de_hi[k]),  32'(HVIS_P[k] * VVIS_P[k]));
      chk("frame_fs_cnt", k, 32'(fs_cnt[k]), 32'd1);
    end
    $display("step: one small frame measured");

    clear_counts();
    repeat (htot(0)) cycle(1'b0);
    chk("line_hs_low", 0, 32'(hs_low[0]), 32'd96);
    chk("line_de_hi",  0, 32'(de_hi[0]),  32'd640);
    chk("line_vs_low", 0, 32'(vs_low[0]), 32'd0);
    $display("step: one full-size line measured");

    repeat (8 * fcyc(1)) cycle(1'b1);
    $display("step: randomized frames done");

    repeat ($urandom_range(100, 2000)) cycle(1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    image_select = 2'd3;
    repeat (2) @(negedge clk);
    check_reset_vals();
    $display("step: mid-frame reset applied");

    rst_n = 1'b1;
    reset_model();
    repeat (2 * fcyc(1) + 100) cycle(1'b1);
    $display("step: post-reset frames done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
